// File: rtl/key_debounce_pkg.sv
// Shared types and default timing for the key debouncer bank.
// Tick defaults assume the 1 MHz system clock.
package key_debounce_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'b000,
    PRESS_WAIT  = 3'b001,
    PRESS_CHECK = 3'b010,
    HELD        = 3'b011,
    REL_WAIT    = 3'b100,
    REL_CHECK   = 3'b101
  } deb_state_t;

  localparam int DEF_PRESS_TICKS   = 10_000;   // 10 ms
  localparam int DEF_RELEASE_TICKS = 200_000;  // 200 ms

  // A key counts as pressed from confirmation until its release is confirmed.
  function automatic logic is_level(input deb_state_t st);
    return (st == HELD) || (st == REL_WAIT) || (st == REL_CHECK);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key: 2-flop synchroniser, polarity fix, press/release FSM
// with wait counter, and registered one-cycle press/release pulses.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int PRESS_TICKS   = DEF_PRESS_TICKS,
  parameter int RELEASE_TICKS = DEF_RELEASE_TICKS,
  parameter int CNT_W         = 18,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk1M,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic             IDLE_RAW     = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_TICKS - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_TICKS - 1);

  logic [1:0]       sync;
  logic             s;
  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_nxt, release_nxt;

  always_ff @(posedge clk1M or posedge rst) begin
    if (rst) sync <= {2{IDLE_RAW}};
    else     sync <= {sync[0], key_in};
  end

  assign s = sync[1] ^ IDLE_RAW;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk1M or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (cnt == PRESS_LAST) state_nxt = PRESS_CHECK;
        else                   cnt_nxt   = cnt + CNT_W'(1);
      end
      PRESS_CHECK: begin
        if (s) begin
          state_nxt = HELD;
          press_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      HELD: begin
        if (!s) begin
          state_nxt = REL_WAIT;
          cnt_nxt   = '0;
        end
      end
      REL_WAIT: begin
        // Lockout: input is ignored until the release window has elapsed.
        if (cnt == RELEASE_LAST) state_nxt = REL_CHECK;
        else                     cnt_nxt   = cnt + CNT_W'(1);
      end
      REL_CHECK: begin
        if (!s) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end else begin
          state_nxt = HELD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign key_level = is_level(state);

endmodule

// File: rtl/key_debounce_bank.sv
// NCH independent key debouncers plus a registered priority encoder that
// reports the lowest-numbered pressed key.
module key_debounce_bank
  import key_debounce_pkg::*;
#(
  parameter int NCH           = 8,
  parameter int PRESS_TICKS   = DEF_PRESS_TICKS,
  parameter int RELEASE_TICKS = DEF_RELEASE_TICKS,
  parameter int CNT_W         = 18,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int CODE_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk1M,
  input  logic              rst,
  input  logic [NCH-1:0]    key_in,
  output logic [NCH-1:0]    key_level,
  output logic [NCH-1:0]    press_pulse,
  output logic [NCH-1:0]    release_pulse,
  output logic              any_pressed,
  output logic [CODE_W-1:0] key_code,
  output logic              code_valid
);

  localparam longint CNT_CAP = longint'(1) << CNT_W;

  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("key_debounce_bank: NCH must be 1..32");
  end
  if (PRESS_TICKS < 1 || RELEASE_TICKS < 1) begin : g_bad_ticks
    $error("key_debounce_bank: PRESS_TICKS and RELEASE_TICKS must be >= 1");
  end
  if (longint'(PRESS_TICKS - 1) >= CNT_CAP ||
      longint'(RELEASE_TICKS - 1) >= CNT_CAP) begin : g_bad_cnt_w
    $error("key_debounce_bank: CNT_W too narrow for the tick counts");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    key_debounce_ch #(
      .PRESS_TICKS   (PRESS_TICKS),
      .RELEASE_TICKS (RELEASE_TICKS),
      .CNT_W         (CNT_W),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_ch (
      .clk1M         (clk1M),
      .rst           (rst),
      .key_in        (key_in[i]),
      .key_level     (key_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

  logic [CODE_W-1:0] code_nxt;

  // Scan high to low so the lowest pressed index is the last one written.
  always_comb begin
    code_nxt = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (key_level[i]) code_nxt = CODE_W'(i);
    end
  end

  always_ff @(posedge clk1M or posedge rst) begin
    if (rst) begin
      any_pressed <= 1'b0;
      code_valid  <= 1'b0;
      key_code    <= '0;
    end else begin
      any_pressed <= |key_level;
      code_valid  <= |key_level;
      key_code    <= code_nxt;
    end
  end

endmodule
